// File: rtl/sr_rf_wb_arbiter_pkg.sv
// rtl/sr_rf_wb_arbiter_pkg.sv - shared types and constants for the register-file writeback arbiter
//
// Purpose: holds the arbiter FSM state enum, the default starvation limit and
//          the writeback port widths so the core and the arbiter agree on them.
// Ports:   none (package).
package sr_rf_wb_arbiter_pkg;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned ADDR_W               = 5;
  localparam int unsigned DATA_W               = 32;
  localparam int unsigned CNT_W                = 4;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_FORCE_P1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sr_rf_wb_arbiter.sv
// rtl/sr_rf_wb_arbiter.sv - two-port writeback arbiter in front of the register-file write port
//
// Purpose: merges the core writeback (p0, priority) and the multi-cycle unit
//          write request (p1) onto the single register-file write port, with a
//          starvation guard that forces p1 through after STARVE_LIMIT waits.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   p0_we/p0_addr/p0_data     core writeback request
//   p0_stall                  core must hold its writeback this cycle (comb)
//   p1_valid/p1_addr/p1_data  multi-cycle unit write request
//   p1_ready                  p1 request accepted when p1_valid is high (comb)
//   rf_we3/rf_a3/rf_wd3       registered register-file write port
//   starve_cnt                consecutive cycles p1 has waited (debug)
module sr_rf_wb_arbiter
  import sr_rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_stall,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              rf_we3,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic [CNT_W-1:0]  starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  arb_state_e       state_next;
  logic             p0_eff;
  logic             p0_win;
  logic             p1_hs;
  logic             p1_starving;
  logic [CNT_W-1:0] cnt_inc;

  // Writes to x0 are architecturally discarded, so they never take the port.
  assign p0_eff      = p0_we && (p0_addr != '0);
  assign p0_win      = p0_eff && !p0_stall;
  assign p1_hs       = p1_valid && p1_ready;
  assign p1_starving = p1_valid && !p1_ready;
  assign cnt_inc     = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    p0_stall   = 1'b0;
    p1_ready   = !p0_eff;
    state_next = state;
    case (state)
      ST_NORMAL: begin
        // Enter the forced cycle on the edge where the wait count reaches the limit.
        if (p1_starving && (cnt_inc == LIMIT)) begin
          state_next = ST_FORCE_P1;
        end
      end
      ST_FORCE_P1: begin
        p0_stall   = 1'b1;
        p1_ready   = 1'b1;
        state_next = ST_NORMAL;
      end
      default: state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (p1_starving) begin
      starve_cnt <= cnt_inc;
    end else begin
      starve_cnt <= '0;
    end
  end

  // p0_win and p1_hs are mutually exclusive: p1_ready is only high when p0 is
  // either not requesting or stalled, so at most one write is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we3 <= 1'b0;
      rf_a3  <= '0;
      rf_wd3 <= '0;
    end else begin
      rf_we3 <= 1'b0;
      if (p0_win) begin
        rf_we3 <= 1'b1;
        rf_a3  <= p0_addr;
        rf_wd3 <= p0_data;
      end else if (p1_hs && (p1_addr != '0)) begin
        rf_we3 <= 1'b1;
        rf_a3  <= p1_addr;
        rf_wd3 <= p1_data;
      end
    end
  end

endmodule
